// File: rtl/led_pattern_gen.sv
// Active-low LED pattern generator: clock-enable divider steps one of four patterns.
// Optional build macro SPEED_SEL_EN adds a speed[1:0] port that shortens the step period to DIV_N >> speed.
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_N = 12000000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
`ifdef SPEED_SEL_EN
  input  logic [1:0]       speed,
`endif
  output logic [WIDTH-1:0] led,
  output logic             step
);

  typedef enum logic [1:0] {
    MODE_ROR    = 2'b00,
    MODE_ROL    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BAR    = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [CNT_W-1:0] DIV_FULL = CNT_W'(DIV_N);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  mode_t            mode_q;
  dir_t             dir;
  logic [1:0]       speed_q;
  logic             speed_chg;
  logic             mode_chg;
  logic             wrap;
  logic [WIDTH-1:0] led_nxt;
  dir_t             dir_nxt;

  // Bar-fill starts dark; every other mode starts with bit 0 lit.
  function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
    if (m == MODE_BAR) return '1;
    return ~WIDTH'(1);
  endfunction

`ifdef SPEED_SEL_EN
  assign speed_chg = (speed != speed_q);
`else
  assign speed_q   = 2'd0;
  assign speed_chg = 1'b0;
`endif

  assign period   = DIV_FULL >> speed_q;
  assign mode_chg = (mode != mode_q);
  assign wrap     = (cnt == period - 1'b1);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    led_nxt = led;
    dir_nxt = dir;
    unique case (mode_q)
      MODE_ROR: led_nxt = {led[0], led[WIDTH-1:1]};
      MODE_ROL: led_nxt = {led[WIDTH-2:0], led[WIDTH-1]};
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT) begin
          led_nxt = {led[WIDTH-2:0], led[WIDTH-1]};
          if (!led_nxt[WIDTH-1]) dir_nxt = DIR_RIGHT;
        end else begin
          led_nxt = {led[0], led[WIDTH-1:1]};
          if (!led_nxt[0]) dir_nxt = DIR_LEFT;
        end
      end
      MODE_BAR: led_nxt = (led == '0) ? '1 : {led[WIDTH-2:0], 1'b0};
      default: led_nxt = led;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      step   <= 1'b0;
      mode_q <= mode_t'(mode);
      dir    <= DIR_LEFT;
      led    <= seed(mode);
`ifdef SPEED_SEL_EN
      speed_q <= speed;
`endif
    end else if (mode_chg) begin
      // A mode change overrides a coincident wrap; no step is taken.
      mode_q <= mode_t'(mode);
      led    <= seed(mode);
      cnt    <= '0;
      dir    <= DIR_LEFT;
      step   <= 1'b0;
`ifdef SPEED_SEL_EN
      speed_q <= speed;
`endif
    end else if (speed_chg) begin
`ifdef SPEED_SEL_EN
      speed_q <= speed;
`endif
      cnt  <= '0;
      step <= 1'b0;
    end else if (!en) begin
      step <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      led  <= led_nxt;
      dir  <= dir_nxt;
      step <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      step <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: an 8-LED and a 4-LED instance share stimulus, DIV_N=8.
module tb_led_pattern_gen;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] mode = 2'b00;
`ifdef SPEED_SEL_EN
  logic [1:0] speed = 2'd0;
`endif
  logic [7:0] led8;
  logic [3:0] led4;
  logic       step8;
  logic       step4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(.WIDTH(8), .DIV_N(DIV), .CNT_W(8)) u_led8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef SPEED_SEL_EN
    .speed(speed),
`endif
    .led(led8), .step(step8)
  );

  led_pattern_gen #(.WIDTH(4), .DIV_N(DIV), .CNT_W(8)) u_led4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
`ifdef SPEED_SEL_EN
    .speed(speed),
`endif
    .led(led4), .step(step4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full step period on the 8-LED instance: quiet for DIV-1 cycles, then new value with a pulse.
  task automatic step8_to(input string tag, input logic [7:0] exp);
    tick(DIV - 1);
    check({tag, "_quiet"}, step8, 1'b0);
    tick();
    check(tag, led8, exp);
    check({tag, "_pulse"}, step8, 1'b1);
  endtask

  task automatic step4_to(input string tag, input logic [3:0] exp);
    tick(DIV - 1);
    check({tag, "_quiet"}, step4, 1'b0);
    tick();
    check(tag, led4, exp);
    check({tag, "_pulse"}, step4, 1'b1);
  endtask

  logic [7:0] ror_seq [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] rol_seq [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
  logic [3:0] bnc_seq [7] = '{4'hD, 4'hB, 4'h7, 4'hB, 4'hD, 4'hE, 4'hD};
  logic [3:0] bar_seq [5] = '{4'hE, 4'hC, 4'h8, 4'h0, 4'hF};

  initial begin
    // Reset with rotate-right selected
    rst = 1'b1; mode = 2'b00; en = 1'b1;
    tick();
    check("rst_led8", led8, 8'hFE);
    check("rst_step8", step8, 1'b0);
    check("rst_led4", led4, 4'hE);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step8_to($sformatf("ror%0d", i), ror_seq[i]);
    tick();
    check("ror_pulse_end", step8, 1'b0);

    // Rotate left (cnt=1 here, mode change clears it)
    mode = 2'b01;
    tick();
    check("rol_seed", led8, 8'hFE);
    check("rol_seed_step", step8, 1'b0);
    for (int i = 0; i < 8; i++) step8_to($sformatf("rol%0d", i), rol_seq[i]);

    // Bounce on 4 LEDs
    mode = 2'b10;
    tick();
    check("bnc_seed", led4, 4'hE);
    for (int i = 0; i < 7; i++) step4_to($sformatf("bnc%0d", i), bnc_seq[i]);

    // Bar fill on 4 LEDs, plus 8-LED bar at the all-lit/all-off boundary
    mode = 2'b11;
    tick();
    check("bar_seed", led4, 4'hF);
    check("bar_seed8", led8, 8'hFF);
    for (int i = 0; i < 5; i++) step4_to($sformatf("bar%0d", i), bar_seq[i]);

    // Freeze with en=0 at cnt=3
    mode = 2'b00;
    tick();
    check("frz_seed", led8, 8'hFE);
    tick(3);
    en = 1'b0;
    tick(20);
    check("frz_led", led8, 8'hFE);
    check("frz_step", step8, 1'b0);
    en = 1'b1;
    tick(4);
    check("frz_quiet", step8, 1'b0);
    check("frz_quiet_led", led8, 8'hFE);
    tick();
    check("frz_resume", led8, 8'h7F);
    check("frz_resume_pulse", step8, 1'b1);

    // Mode change coincident with wrap: change wins, no pulse
    tick(DIV - 1);
    mode = 2'b10;
    tick();
    check("chg_led", led8, 8'hFE);
    check("chg_step", step8, 1'b0);
    step8_to("chg_next", 8'hFD);

    // Reset mid-period discards the partial count
    tick(3);
    rst = 1'b1;
    tick();
    check("mid_rst_led", led8, 8'hFE);
    check("mid_rst_step", step8, 1'b0);
    rst = 1'b0;
    step8_to("mid_rst_next", 8'hFD);

`ifdef SPEED_SEL_EN
    // Speed change clears the divider only; period becomes DIV>>2 = 2
    speed = 2'd2;
    tick();
    check("spd_led", led8, 8'hFD);
    check("spd_step", step8, 1'b0);
    tick();
    check("spd_quiet", step8, 1'b0);
    tick();
    check("spd_next", led8, 8'hFB);
    check("spd_pulse", step8, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
